// File: rtl/hack_mem_pkg.sv
// Shared defaults, FSM state encoding and the address range helper for the RAM responder.
package hack_mem_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_WORDS_DEF = 16384;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
        return addr < words;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port word store: synchronous write, one-cycle registered read, no reset.
// Out-of-range writes are dropped and out-of-range reads return zero.
module ram_array
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        idx      = addr[IDX_W-1:0];
        in_range = addr_in_range(32'(addr), MEM_WORDS);
        rdata_d  = in_range ? mem[idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Valid/ready RAM front end: reads answer 2 cycles after acceptance and hold until rsp_ready;
// writes stay in IDLE (one per cycle) unless RAM_WRITE_ACK_EN adds a one-beat write echo.
module ram_responder
#(
    parameter int ADDR_W    = hack_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W    = hack_mem_pkg::DATA_W_DEF,
    parameter int MEM_WORDS = hack_mem_pkg::MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_out
);

    import hack_mem_pkg::*;

    state_t            state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              accept;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // Gating on reset_n keeps a request on a reset edge from being accepted or written.
    always_comb begin
        req_ready = reset_n && (state_q == IDLE);
        accept    = req_valid && req_ready;
        ram_we    = accept && req_load;
        ram_addr  = (state_q == IDLE) ? req_address : addr_q;
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        addr_d      = addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_load) begin
`ifdef RAM_WRITE_ACK_EN
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_out_d   = addr_in_range(32'(req_address), MEM_WORDS) ? req_in : '0;
`endif
                    end else begin
                        addr_d  = req_address;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                rsp_out_d   = ram_rdata;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            addr_q      <= addr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_out   = rsp_out_q;

    ram_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_ram_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req_in),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed vector table, corner sequences and a randomized run against a word map.
module tb_ram_responder;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 16;
    localparam int MEM_WORDS = 16384;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_out;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [int];

    always #5 clk = ~clk;

    ram_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_load    (req_load),
        .req_address (req_address),
        .req_in      (req_in),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_out     (rsp_out)
    );

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                hold;
        logic [DATA_W-1:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input int addr);
        if (addr >= MEM_WORDS) return '0;
        return model[addr];
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20 && !req_ready; i++) step();
        check("wait_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wait_ready();
        req_valid   = 1'b1;
        req_load    = 1'b1;
        req_address = addr;
        req_in      = data;
        step();
        req_valid = 1'b0;
        if (int'(addr) < MEM_WORDS) model[int'(addr)] = data;
`ifdef RAM_WRITE_ACK_EN
        check("wack_valid", {31'd0, rsp_valid}, 32'd1);
        check("wack_data", {16'd0, rsp_out}, {16'd0, (int'(addr) < MEM_WORDS) ? data : 16'h0000});
        check("wack_busy", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wack_done", {31'd0, rsp_valid}, 32'd0);
        check("wack_idle", {31'd0, req_ready}, 32'd1);
`else
        check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("wr_idle", {31'd0, req_ready}, 32'd1);
`endif
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input int hold, input logic [DATA_W-1:0] exp);
        wait_ready();
        req_valid   = 1'b1;
        req_load    = 1'b0;
        req_address = addr;
        step();
        req_valid = 1'b0;
        check("rd_access_valid", {31'd0, rsp_valid}, 32'd0);
        check("rd_access_busy", {31'd0, req_ready}, 32'd0);
        step();
        check("rd_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_data", {16'd0, rsp_out}, {16'd0, exp});
        for (int i = 0; i < hold; i++) begin
            step();
            check("rd_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("rd_hold_data", {16'd0, rsp_out}, {16'd0, exp});
            check("rd_hold_busy", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("rd_consume_busy", {31'd0, req_ready}, 32'd0);
        step();
        rsp_ready = 1'b0;
        check("rd_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("rd_done_idle", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        int   addr_pool[12];

        tbl[0]  = '{1'b1, 15'h0005, 16'h1234, 0, 16'h0000};
        tbl[1]  = '{1'b0, 15'h0005, 16'h0000, 0, 16'h1234};
        tbl[2]  = '{1'b1, 15'h0000, 16'h5A5A, 0, 16'h0000};
        tbl[3]  = '{1'b1, 15'h4000, 16'hBEEF, 0, 16'h0000};
        tbl[4]  = '{1'b0, 15'h4000, 16'h0000, 0, 16'h0000};
        tbl[5]  = '{1'b0, 15'h0000, 16'h0000, 0, 16'h5A5A};
        tbl[6]  = '{1'b0, 15'h0005, 16'h0000, 4, 16'h1234};
        tbl[7]  = '{1'b1, 15'h3FFF, 16'h8001, 0, 16'h0000};
        tbl[8]  = '{1'b0, 15'h3FFF, 16'h0000, 1, 16'h8001};
        tbl[9]  = '{1'b1, 15'h7FFF, 16'h1111, 0, 16'h0000};
        tbl[10] = '{1'b0, 15'h7FFF, 16'h0000, 2, 16'h0000};

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_load    = 1'b0;
        req_address = '0;
        req_in      = '0;
        rsp_ready   = 1'b0;
        #1;
        check("rst_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        step();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_out", {16'd0, rsp_out}, 32'd0);
        check("rst_ready_hold", {31'd0, req_ready}, 32'd0);
        reset_n = 1'b1;
        step();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data);
            else              do_read(tbl[i].addr, tbl[i].hold, tbl[i].exp);
        end

`ifdef RAM_WRITE_ACK_EN
        do_write(15'h0010, 16'h00FF);
        for (int a = 1; a <= 4; a++) do_write(15'(a), 16'(a));
`else
        wait_ready();
        for (int a = 1; a <= 4; a++) begin
            req_valid   = 1'b1;
            req_load    = 1'b1;
            req_address = 15'(a);
            req_in      = 16'(a);
            check("b2b_ready", {31'd0, req_ready}, 32'd1);
            step();
            model[a] = 16'(a);
        end
        req_valid = 1'b0;
        check("b2b_no_rsp", {31'd0, rsp_valid}, 32'd0);
`endif
        for (int a = 1; a <= 4; a++) do_read(15'(a), 0, 16'(a));

        // Reset while a read response is pending, with a write presented on the reset edge.
        wait_ready();
        req_valid   = 1'b1;
        req_load    = 1'b0;
        req_address = 15'h0005;
        step();
        req_valid = 1'b0;
        step();
        check("rstresp_pending", {31'd0, rsp_valid}, 32'd1);
        reset_n     = 1'b0;
        req_valid   = 1'b1;
        req_load    = 1'b1;
        req_in      = 16'hDEAD;
        #1;
        check("rstresp_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        check("rstresp_valid_clr", {31'd0, rsp_valid}, 32'd0);
        check("rstresp_out_clr", {16'd0, rsp_out}, 32'd0);
        reset_n   = 1'b1;
        req_valid = 1'b0;
        step();
        check("rstresp_ready", {31'd0, req_ready}, 32'd1);
        check("rstresp_no_stale", {31'd0, rsp_valid}, 32'd0);
        do_read(15'h0005, 0, 16'h1234);

        addr_pool = '{0, 1, 7, 15, 100, 8191, 16382, 16383, 16384, 16385, 20000, 32767};
        for (int n = 0; n < 150; n++) begin
            int  a;
            bit  wr;
            a  = addr_pool[$urandom_range(0, 11)];
            wr = ($urandom_range(0, 1) == 1) || (a < MEM_WORDS && !model.exists(a));
            if (wr) do_write(15'(a), 16'($urandom));
            else    do_read(15'(a), int'($urandom_range(0, 3)), model_read(a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning the width of the word address.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the width of the data word.
REQ-003 SHALL have parameter MEM_WORDS, default 16384, meaning the number of implemented words (at most 2**ADDR_W).
REQ-004 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, width 1: synchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, width 1: the request is present.
REQ-007 SHALL have port req_ready, output, width 1: the block accepts a request this cycle.
REQ-008 SHALL have port req_load, input, width 1: 1 means write, 0 means read.
REQ-009 SHALL have port req_address, input, width ADDR_W: the word address.
REQ-010 SHALL have port req_in, input, width DATA_W: the write data.
REQ-011 SHALL have port rsp_valid, output, width 1: the response is present.
REQ-012 SHALL have port rsp_ready, input, width 1: the consumer takes the response.
REQ-013 SHALL have port rsp_out, output, width DATA_W: the response data.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-015 SHALL use FSM states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL, for an accepted write with req_address < MEM_WORDS, write req_in to the array on the accepting edge.
REQ-017 SHALL, for an accepted write without RAM_WRITE_ACK_EN, remain in IDLE, giving one write per cycle.
REQ-018 SHALL, for an accepted read, register the address and go IDLE->ACCESS.
REQ-019 SHALL, in ACCESS, load the array output into rsp_out, set rsp_valid=1 and go to RESP; first rsp_valid is 2 cycles after acceptance.
REQ-020 SHALL, in RESP, hold rsp_valid and rsp_out stable until rsp_ready=1, then clear rsp_valid and go to IDLE on that edge.
REQ-021 SHALL NOT set req_ready in the same cycle the response is consumed; the minimum read period is 3 cycles.
REQ-022 SHALL ignore writes with address >= MEM_WORDS (array unchanged); reads at such addresses SHALL return 0.
REQ-023 SHALL return the newly written value for a read following a write to the same address.
REQ-024 SHALL ignore rsp_ready while rsp_valid=0, and ignore req_valid outside IDLE.

Reset
REQ-025 SHALL, while reset_n=0 at a rising edge, force state IDLE, rsp_valid=0 and rsp_out=0; req_ready SHALL be 0 during reset.
REQ-026 SHALL, on reset in ACCESS or RESP, discard the pending response; a write accepted on a reset edge SHALL NOT be performed.
REQ-027 SHALL NOT reset or initialise array contents.

Configuration
REQ-028 SHALL, with macro RAM_WRITE_ACK_EN defined, treat an accepted in-range write as IDLE->RESP with rsp_out=req_in and rsp_valid=1 on the next cycle.
REQ-029 SHALL, with RAM_WRITE_ACK_EN defined, treat an out-of-range write as IDLE->RESP with rsp_out=0.
REQ-030 SHALL, without RAM_WRITE_ACK_EN, produce no response beat for any write.

Structure
REQ-031 SHALL place the ADDR_W/DATA_W defaults and the FSM state enum in shared package hack_mem_pkg.
REQ-032 SHALL implement the storage as sub-module ram_array: single-port, synchronous write, one-cycle registered read, no reset.

Verification
REQ-033 SHALL cover: reset, then write 0x1234 to address 0x0005, then read 0x0005 -> rsp_valid=1 two cycles after acceptance, rsp_out=0x1234.
REQ-034 SHALL cover: a read with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_out stable, req_ready=0 throughout, IDLE the cycle after rsp_ready=1.
REQ-035 SHALL cover: write 0xBEEF to 0x4000 (>= MEM_WORDS), then read 0x4000 -> rsp_out=0x0000; address 0x0000 unchanged.
REQ-036 SHALL cover: back-to-back writes 0x0001..0x0004 to addresses 1..4 with req_valid held -> 4 acceptances in 4 cycles (without macro); readback matches.
REQ-037 SHALL cover: reset_n=0 during RESP -> rsp_valid=0 next cycle; after release, req_ready=1 and no stale response.
REQ-038 SHALL cover, with RAM_WRITE_ACK_EN: write 0x00FF to 0x0010 -> one response beat with rsp_out=0x00FF, then IDLE.
